// File: rtl/multi_edge_sync_filter_if.sv
// multi_edge_sync_filter_if
// Bundles the per-channel inputs and outputs of multi_edge_sync_filter.
//   async_i  : raw asynchronous channel inputs
//   en_i     : per-channel pulse enable
//   clr_i    : per-channel write-1-to-clear for sticky_o
//   level_o  : filtered synchronized level
//   pulse_o  : one-cycle pulse per accepted edge
//   sticky_o : latched event flag
//   any_o    : OR of pulse_o
// slave is the filter side, master is the consumer/driver side.
interface multi_edge_sync_filter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] async_i;
  logic [WIDTH-1:0] en_i;
  logic [WIDTH-1:0] clr_i;
  logic [WIDTH-1:0] level_o;
  logic [WIDTH-1:0] pulse_o;
  logic [WIDTH-1:0] sticky_o;
  logic             any_o;

  modport master (
    output async_i, en_i, clr_i,
    input  level_o, pulse_o, sticky_o, any_o
  );

  modport slave (
    input  async_i, en_i, clr_i,
    output level_o, pulse_o, sticky_o, any_o
  );
endinterface

// File: rtl/multi_edge_sync_filter.sv
// multi_edge_sync_filter
// Multi-channel receive-side synchronizer: per channel a SYNC_STAGES flop
// chain, a FILTER_LEN persistence filter, an edge detector that emits
// one-cycle pulses and a software-cleared sticky flag.
//   clk_i  : local clock, all logic in this domain
//   rst_ni : asynchronous active-low reset
//   bus    : multi_edge_sync_filter_if.slave (async_i/en_i/clr_i in,
//            level_o/pulse_o/sticky_o/any_o out)

// One channel. Instantiated as an array by the top.
module mesf_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   EDGE_MODE   = 0,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  input  logic en_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic sticky_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  // First two stages are the metastability-resolving pair.
  (* ASYNC_REG = "TRUE" *) logic [1:0] meta_q;
  logic s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) meta_q <= {2{RST_VAL}};
    else         meta_q <= {meta_q[0], async_i};
  end

  generate
    if (SYNC_STAGES > 2) begin : g_tail
      logic [SYNC_STAGES-3:0] tail_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tail_q <= {(SYNC_STAGES-2){RST_VAL}};
        else         tail_q <= (SYNC_STAGES-2)'({tail_q, meta_q[1]});
      end
      assign s = tail_q[SYNC_STAGES-3];
    end else begin : g_short
      assign s = meta_q[1];
    end
  endgenerate

  logic [CW-1:0] cnt_q;
  logic          level_q, pulse_q, sticky_q;
  logic          accept, edge_ok;

  // cnt_q counts cycles s has already differed from level_q; the current
  // differing cycle makes FILTER_LEN, so accept on FILTER_LEN-1.
  assign accept  = (s != level_q) && (cnt_q == CW'(FILTER_LEN - 1));
  // s is the new level at acceptance, so it alone tells rise from fall.
  assign edge_ok = (EDGE_MODE == 0) ? 1'b1 : (EDGE_MODE == 1) ? s : !s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      level_q  <= RST_VAL;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      // Gating only the pulse keeps level tracking alive while disabled.
      pulse_q  <= accept && en_i && edge_ok;
      // Set wins over a simultaneous clear.
      sticky_q <= pulse_q | (sticky_q & ~clr_i);
      if (s == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= s;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign sticky_o = sticky_q;
endmodule

module multi_edge_sync_filter #(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter int   EDGE_MODE   = 0,
  parameter logic RST_VAL     = 1'b0
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  multi_edge_sync_filter_if.slave bus
);
  logic [WIDTH-1:0] async_v, en_v, clr_v;
  logic [WIDTH-1:0] level, pulse, sticky;

  assign async_v = bus.async_i;
  assign en_v    = bus.en_i;
  assign clr_v   = bus.clr_i;

  mesf_lane #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .EDGE_MODE   (EDGE_MODE),
    .RST_VAL     (RST_VAL)
  ) u_lane [WIDTH-1:0] (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .async_i  (async_v),
    .en_i     (en_v),
    .clr_i    (clr_v),
    .level_o  (level),
    .pulse_o  (pulse),
    .sticky_o (sticky)
  );

  assign bus.level_o  = level;
  assign bus.pulse_o  = pulse;
  assign bus.sticky_o = sticky;
  assign bus.any_o    = |pulse;
endmodule

// File: tb/tb_multi_edge_sync_filter.sv
// Bench: three DUTs (EDGE_MODE 0/1/2) share one stimulus stream. A model
// built on the logged input history predicts outputs after each edge and
// queues them; a monitor pops and compares just after every clock edge.
module tb_multi_edge_sync_filter;
  localparam int   W   = 8;
  localparam int   SS  = 2;
  localparam int   F   = 4;
  localparam logic RST = 1'b0;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  multi_edge_sync_filter_if #(.WIDTH(W)) bus0 ();
  multi_edge_sync_filter_if #(.WIDTH(W)) bus1 ();
  multi_edge_sync_filter_if #(.WIDTH(W)) bus2 ();

  multi_edge_sync_filter #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(F), .EDGE_MODE(0), .RST_VAL(RST))
    u_dut0 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus0));
  multi_edge_sync_filter #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(F), .EDGE_MODE(1), .RST_VAL(RST))
    u_dut1 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus1));
  multi_edge_sync_filter #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(F), .EDGE_MODE(2), .RST_VAL(RST))
    u_dut2 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus2));

  logic [2:0][W-1:0] lvl_w, pul_w, stk_w;
  logic [2:0]        any_w;
  assign lvl_w = {bus2.level_o,  bus1.level_o,  bus0.level_o};
  assign pul_w = {bus2.pulse_o,  bus1.pulse_o,  bus0.pulse_o};
  assign stk_w = {bus2.sticky_o, bus1.sticky_o, bus0.sticky_o};
  assign any_w = {bus2.any_o,    bus1.any_o,    bus0.any_o};

  typedef struct packed {
    logic [W-1:0]      level;
    logic [2:0][W-1:0] pulse;
    logic [2:0][W-1:0] sticky;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input int m, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s mode%0d cyc%0d: got %h expected %h", name, m, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // in_log[t] = async_i value sampled at edge t since the last reset release.
  // The synchronized value seen after edge t is the input from SS-1 edges
  // earlier (reset value before that). A level flips at edge t exactly when
  // the F synchronized samples preceding that edge all differ from it.
  logic [W-1:0]      in_log[$];
  logic [W-1:0]      m_lvl;
  logic [2:0][W-1:0] m_pulse, m_sticky;
  logic [W-1:0]      cur_a, cur_e, cur_c;

  function automatic logic [W-1:0] s_at(int t);
    if (t - SS + 1 >= 0) return in_log[t - SS + 1];
    return {W{RST}};
  endfunction

  task automatic model_reset();
    in_log.delete();
    m_lvl    = {W{RST}};
    m_pulse  = '0;
    m_sticky = '0;
  endtask

  task automatic model_step(input logic [W-1:0] a, input logic [W-1:0] e, input logic [W-1:0] c);
    int t;
    logic [W-1:0] smp;
    logic [W-1:0] acc;
    exp_t x;
    in_log.push_back(a);
    t   = in_log.size() - 1;
    acc = '1;
    for (int j = 1; j <= F; j++) begin
      smp = s_at(t - j);
      acc = acc & (smp ^ m_lvl);
    end
    for (int m = 0; m < 3; m++) begin
      for (int n = 0; n < W; n++) begin
        m_sticky[m][n] = m_pulse[m][n] ? 1'b1 : (c[n] ? 1'b0 : m_sticky[m][n]);
        m_pulse[m][n]  = acc[n] && e[n] &&
                         (m == 0 || (m == 1 && !m_lvl[n]) || (m == 2 && m_lvl[n]));
      end
    end
    m_lvl    = m_lvl ^ acc;
    x.level  = m_lvl;
    x.pulse  = m_pulse;
    x.sticky = m_sticky;
    exp_q.push_back(x);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] e, input logic [W-1:0] c);
    cur_a = a; cur_e = e; cur_c = c;
    bus0.async_i = a; bus0.en_i = e; bus0.clr_i = c;
    bus1.async_i = a; bus1.en_i = e; bus1.clr_i = c;
    bus2.async_i = a; bus2.en_i = e; bus2.clr_i = c;
  endtask

  // One cycle: drive on negedge, predict what the next posedge produces.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] e, input logic [W-1:0] c);
    @(negedge clk_i);
    drive(a, e, c);
    model_step(a, e, c);
  endtask

  task automatic check_zero(input string name);
    for (int m = 0; m < 3; m++) begin
      chk({name, "_level"},  m, lvl_w[m], {W{RST}});
      chk({name, "_pulse"},  m, pul_w[m], '0);
      chk({name, "_sticky"}, m, stk_w[m], '0);
      chk({name, "_any"},    m, W'(any_w[m]), '0);
    end
  endtask

  task automatic reset_assert(input string name);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_zero(name);
    model_reset();
  endtask

  // Release on a negedge; the following posedge samples cur_* as edge 0.
  task automatic reset_release();
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_step(cur_a, cur_e, cur_c);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        cyc++;
        for (int m = 0; m < 3; m++) begin
          chk("level",  m, lvl_w[m], x.level);
          chk("pulse",  m, pul_w[m], x.pulse[m]);
          chk("sticky", m, stk_w[m], x.sticky[m]);
          chk("any",    m, W'(any_w[m]), W'(|x.pulse[m]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, e, c;
    rst_ni = 1'b0;
    drive('0, '1, '0);
    model_reset();
    @(negedge clk_i);
    #1;
    check_zero("reset");
    reset_release();

    // ch0 rise held: pulse 5 edges after capture, sticky one later.
    repeat (3) step('0, '1, '0);
    repeat (10) step(8'h01, '1, '0);

    // ch3 glitch of 2 cycles is dropped, 6 cycles is accepted.
    repeat (2) step(8'h09, '1, '0);
    repeat (10) step(8'h01, '1, '0);
    repeat (6) step(8'h09, '1, '0);
    repeat (10) step(8'h01, '1, '0);

    // ch1 square wave, period 20.
    for (int p = 0; p < 3; p++) begin
      repeat (10) step(8'h03, '1, '0);
      repeat (10) step(8'h01, '1, '0);
    end

    // ch2 edge while disabled, then re-enable: no stale pulse.
    repeat (10) step(8'h05, 8'hFB, '0);
    repeat (5)  step(8'h05, '1, '0);
    repeat (10) step(8'h01, '1, '0);

    // ch5 clear coincident with the pulse cycle, then a lone clear.
    for (int i = 0; i < 10; i++) step(8'h21, '1, {2'b00, m_pulse[0][5], 5'b0});
    repeat (3) step(8'h21, '1, '0);
    step(8'h21, '1, 8'h20);
    repeat (3) step(8'h21, '1, '0);

    // Reset during filtering on ch0 (cnt reaches 2), input held high.
    repeat (10) step(8'h00, '1, '0);
    repeat (4) step(8'h01, '1, '0);
    reset_assert("midreset");
    repeat (2) @(negedge clk_i);
    reset_release();
    repeat (10) step(8'h01, '1, '0);

    // Randomized traffic with occasional disables and clears.
    a = 8'h01;
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < W; n++) begin
        if ($urandom_range(0, 5) == 0) a[n] = ~a[n];
        e[n] = ($urandom_range(0, 7) != 0);
        c[n] = ($urandom_range(0, 7) == 0);
      end
      step(a, e, c);
      if (i == 400) begin
        reset_assert("randreset");
        @(negedge clk_i);
        reset_release();
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
